// File: rtl/systolic_row_feeder.sv
// Skewed row feeder for a DEPTH x DEPTH systolic array.
// Snapshots a matrix on start and streams it diagonally, one step per cycle.
module systolic_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stall,
  input  logic [DEPTH*DEPTH*DATA_WIDTH-1:0] matrix_in,
  output logic [DEPTH*DATA_WIDTH-1:0]       row_data,
  output logic [DEPTH-1:0]                  row_valid,
  output logic [$clog2(2*DEPTH)-1:0]        step,
  output logic                              busy,
  output logic                              done
);

  localparam int SW = $clog2(2*DEPTH);
  localparam logic [SW-1:0] LAST = SW'(2*DEPTH-2);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_e;

  state_e state_q, state_d;
  logic [SW-1:0] t_q, t_d;
  logic [DATA_WIDTH-1:0] mat_q [DEPTH][DEPTH];
  logic load_en;

  logic [DEPTH*DATA_WIDTH-1:0] row_data_q, row_data_d;
  logic [DEPTH-1:0] row_valid_q, row_valid_d;
  logic [SW-1:0] step_q, step_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [DEPTH*DATA_WIDTH-1:0] skew_data;
  logic [DEPTH-1:0] skew_valid;

  // Lane r at step t carries M[r][t-r] when that column exists.
  always_comb begin
    skew_data  = '0;
    skew_valid = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < DEPTH; c++) begin
        if (t_q == SW'(r + c)) begin
          skew_data[r*DATA_WIDTH +: DATA_WIDTH] = mat_q[r][c];
          skew_valid[r] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    load_en     = 1'b0;
    row_data_d  = row_data_q;
    row_valid_d = row_valid_q;
    step_d      = step_q;
    busy_d      = busy_q;
    done_d      = done_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          load_en = 1'b1;
          t_d     = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!stall) begin
          row_data_d  = skew_data;
          row_valid_d = skew_valid;
          step_d      = t_q;
          busy_d      = 1'b1;
          if (t_q == LAST) begin
            state_d = FINISH;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      FINISH: begin
        if (!stall) begin
          row_data_d  = '0;
          row_valid_d = '0;
          step_d      = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      t_q         <= '0;
      row_data_q  <= '0;
      row_valid_q <= '0;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      row_data_q  <= row_data_d;
      row_valid_q <= row_valid_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < DEPTH; c++) begin
        if (reset) begin
          mat_q[r][c] <= '0;
        end else if (load_en) begin
          mat_q[r][c] <=
            matrix_in[(r*DEPTH+c)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign row_data  = row_data_q;
  assign row_valid = row_valid_q;
  assign step      = step_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed bench for systolic_row_feeder (DEPTH=8, DATA_WIDTH=8).
// Matrix M[r][c] = r*8+c+1; expected lanes come from the skew formula.
module tb_systolic_row_feeder;

  localparam int DW = 8;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic reset, start, stall;
  logic [D*D*DW-1:0] matrix_in;
  logic [D*DW-1:0] row_data;
  logic [D-1:0] row_valid;
  logic [3:0] step;
  logic busy, done;

  int checks = 0;
  int failures = 0;

  systolic_row_feeder #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stall(stall),
    .matrix_in(matrix_in),
    .row_data(row_data),
    .row_valid(row_valid),
    .step(step),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [D*D*DW-1:0] ref_matrix();
    logic [D*D*DW-1:0] m;
    m = '0;
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        m[(r*D+c)*DW +: DW] = 8'(r*8 + c + 1);
    return m;
  endfunction

  function automatic logic [63:0] exp_data(input int t);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < D; r++)
      if (t - r >= 0 && t - r <= D - 1)
        v[r*DW +: DW] = 8'(r*8 + (t - r) + 1);
    return v;
  endfunction

  function automatic logic [63:0] exp_valid(input int t);
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < D; r++)
      if (t - r >= 0 && t - r <= D - 1)
        v[r] = 1'b1;
    return v;
  endfunction

  task automatic chk_step(input int t);
    chk($sformatf("data_t%0d", t), 64'(row_data), exp_data(t));
    chk($sformatf("valid_t%0d", t), 64'(row_valid), exp_valid(t));
    chk($sformatf("step_t%0d", t), 64'(step), 64'(t));
    chk($sformatf("busy_t%0d", t), 64'(busy), 64'd1);
    chk($sformatf("done_t%0d", t), 64'(done), 64'd0);
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_data"}, 64'(row_data), 64'd0);
    chk({tag, "_valid"}, 64'(row_valid), 64'd0);
    chk({tag, "_step"}, 64'(step), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    stall = 1'b1;
    matrix_in = ref_matrix();

    // Reset overrides start and stall, and holds IDLE.
    tick();
    chk_idle("rst0", 1'b0);
    tick();
    tick();
    chk_idle("rst_hold", 1'b0);
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    tick();
    chk_idle("post_rst", 1'b0);

    // Stream 1: overwrite input at k+3, stray start at k+5.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 14; t++) begin
      if (t == 2) matrix_in = '1;
      if (t == 4) start = 1'b1;
      tick();
      start = 1'b0;
      chk_step(t);
      if (t == 0) begin
        chk("s1_lane0_k1", 64'(row_data[7:0]), 64'h01);
        chk("s1_valid_k1", 64'(row_valid), 64'h01);
      end
      if (t == 7) begin
        chk("s1_lane0_k8", 64'(row_data[7:0]), 64'h08);
        chk("s1_lane7_k8", 64'(row_data[63:56]), 64'h39);
        chk("s1_valid_k8", 64'(row_valid), 64'hFF);
      end
      if (t == 14) begin
        chk("s1_lane7_k15", 64'(row_data[63:56]), 64'h40);
        chk("s1_valid_k15", 64'(row_valid), 64'h80);
      end
    end
    tick();
    chk_idle("s1_done", 1'b1);
    tick();
    chk_idle("s1_after", 1'b0);

    // Stream 2: stall three cycles while step 5 is presented.
    matrix_in = ref_matrix();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      tick();
      chk_step(t);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_step(5);
    end
    stall = 1'b0;
    for (int t = 6; t <= 14; t++) begin
      tick();
      chk_step(t);
    end
    tick();
    chk_idle("s2_done_k19", 1'b1);

    // Start held in the done cycle is accepted.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_idle("s3_accept", 1'b0);
    tick();
    chk_step(0);
    chk("s3_lane0", 64'(row_data[7:0]), 64'h01);
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk_step(t);
    end

    // Reset at step 7 aborts without done.
    reset = 1'b1;
    tick();
    chk_idle("abort", 1'b0);
    reset = 1'b0;
    tick();
    chk_idle("abort_idle", 1'b0);
    tick();
    chk_idle("abort_nodone", 1'b0);

    // Restart after abort; stall ignored in IDLE.
    start = 1'b1;
    stall = 1'b1;
    tick();
    start = 1'b0;
    stall = 1'b0;
    for (int t = 0; t <= 14; t++) begin
      tick();
      chk_step(t);
    end
    tick();
    chk_idle("s4_done", 1'b1);
    tick();
    chk_idle("s4_after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
